// File: rtl/nonce_issue.sv
// Work-range nonce issuer: latches a header word and nonce range, emits one nonce per cycle,
// then signals done once the last nonce has had time to drain through the hash pipeline.
module nonce_issue #(
    parameter int unsigned CNT_W      = 32,
    parameter int unsigned PIPE_DEPTH = 96
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid,
    input  logic [63:0]      m04Base,
    input  logic [CNT_W-1:0] nonceStart,
    input  logic [CNT_W-1:0] nonceEnd,
    input  logic             hold,
    output logic             vldOut,
    output logic [63:0]      m04Out,
    output logic             busy,
    output logic             done
);

    localparam int unsigned DRAIN_W = (PIPE_DEPTH > 1) ? $clog2(PIPE_DEPTH) : 1;

    // Masks split the 64-bit word into the pass-through header bits and the counted field;
    // with CNT_W=64 the header part is empty and HI_MASK is all zeros.
    localparam logic [63:0]        LO_MASK    = {64{1'b1}} >> (64 - CNT_W);
    localparam logic [63:0]        HI_MASK    = ~LO_MASK;
    localparam logic [DRAIN_W-1:0] DRAIN_INIT = DRAIN_W'(PIPE_DEPTH - 1);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDrain
    } state_e;

    state_e             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   end_q;
    logic [63:0]        base_hi_q;
    logic [DRAIN_W-1:0] drain_q;

    assign busy = (state_q != StIdle);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            end_q     <= '0;
            base_hi_q <= '0;
            drain_q   <= '0;
            vldOut    <= 1'b0;
            m04Out    <= '0;
            done      <= 1'b0;
        end else begin
            vldOut <= 1'b0;
            done   <= 1'b0;
            if (valid) begin
                // New work aborts whatever range was in flight, including a pending done.
                base_hi_q <= m04Base & HI_MASK;
                cnt_q     <= nonceStart;
                end_q     <= nonceEnd;
                state_q   <= StRun;
            end else begin
                case (state_q)
                    StRun: begin
                        if (!hold) begin
                            vldOut <= 1'b1;
                            m04Out <= base_hi_q | 64'(cnt_q);
                            if (cnt_q == end_q) begin
                                state_q <= StDrain;
                                drain_q <= DRAIN_INIT;
                            end else begin
                                cnt_q <= cnt_q + 1'b1;
                            end
                        end
                    end
                    StDrain: begin
                        if (drain_q != '0) begin
                            drain_q <= drain_q - 1'b1;
                        end else begin
                            done    <= 1'b1;
                            state_q <= StIdle;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_nonce_issue.sv
// Self-checking bench for nonce_issue: directed scenarios plus random traffic, compared against
// a range/countdown reference model; a second instance covers the 64-bit, depth-1 corner.
module tb_nonce_issue;

    localparam int unsigned DEPTH = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        valid, hold;
    logic [63:0] base;
    logic [31:0] nstart, nend;
    logic        vld, busy, done;
    logic [63:0] m04;

    logic        valid_w, hold_w;
    logic [63:0] base_w, start_w, end_w;
    logic        vld_w, busy_w, done_w;
    logic [63:0] m04_w;

    nonce_issue #(.CNT_W(32), .PIPE_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .valid(valid), .m04Base(base), .nonceStart(nstart),
        .nonceEnd(nend), .hold(hold), .vldOut(vld), .m04Out(m04), .busy(busy), .done(done)
    );

    nonce_issue #(.CNT_W(64), .PIPE_DEPTH(1)) dut64 (
        .clk(clk), .rst(rst), .valid(valid_w), .m04Base(base_w), .nonceStart(start_w),
        .nonceEnd(end_w), .hold(hold_w), .vldOut(vld_w), .m04Out(m04_w), .busy(busy_w),
        .done(done_w)
    );

    int errors = 0;
    int checks = 0;

    // Reference model: remaining nonce count, next nonce, and the cycle at which done is due.
    bit              m_run;
    longint unsigned m_rem;
    logic [31:0]     m_next, m_hi;
    longint          m_done_at, cyc;
    logic            e_vld, e_done;
    logic [63:0]     e_m04;

    task automatic model_reset();
        m_run = 0; m_rem = 0; m_next = 0; m_hi = 0; m_done_at = -1;
        e_vld = 0; e_done = 0; e_m04 = 0;
    endtask

    task automatic step(input logic v, input logic h, input logic [31:0] s,
                        input logic [31:0] e, input logic [31:0] hi);
        logic [31:0] d;
        valid = v; hold = h; nstart = s; nend = e; base = {hi, $urandom()};
        @(posedge clk);
        cyc++;
        e_vld = 0; e_done = 0;
        if (v) begin
            d = e - s;
            m_hi = hi; m_next = s; m_rem = {32'b0, d} + 64'd1;
            m_run = 1; m_done_at = -1;
        end else if (m_run && m_rem != 0 && !h) begin
            e_vld = 1; e_m04 = {m_hi, m_next};
            m_next = m_next + 32'd1;
            m_rem = m_rem - 1;
            if (m_rem == 0) m_done_at = cyc + DEPTH;
        end else if (m_run && m_done_at == cyc) begin
            e_done = 1; m_run = 0; m_done_at = -1;
        end
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        valid = 0; hold = 0; base = 0; nstart = 0; nend = 0;
        valid_w = 0; hold_w = 0; base_w = 0; start_w = 0; end_w = 0;
        model_reset();
        #3;
        checks++;
        if ({vld, done, busy, m04} !== 67'b0) begin
            errors++;
            $display("FAIL reset_init got vld=%b done=%b busy=%b m04=%h want all 0",
                     vld, done, busy, m04);
        end
        @(negedge clk) rst = 1'b0;
        step(1, 0, 32'd0, 32'd20, 32'h1111_2222);
        repeat (3) step(0, 0, 0, 0, 0);
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({vld, busy, m04} !== 66'b0) begin
            errors++;
            $display("FAIL reset_mid_run got vld=%b busy=%b m04=%h want 0 0 0", vld, busy, m04);
        end
        model_reset();
        @(negedge clk) rst = 1'b0;
        for (int i = 0; i < 30; i++) begin
            step(0, 0, 0, 0, 0);
            checks++;
            if ({vld, done, busy, m04} !== {e_vld, e_done, m_run, e_m04}) begin
                errors++;
                $display("FAIL reset_after cyc=%0d got vld=%b done=%b busy=%b m04=%h want %b %b %b %h",
                         cyc, vld, done, busy, m04, e_vld, e_done, m_run, e_m04);
            end
        end
    endtask

    task automatic test_basic();
        logic [31:0] got[$];
        longint last_issue, done_cyc;
        done_cyc = -1; last_issue = -1;
        step(1, 0, 32'd5, 32'd8, 32'hAABB_CCDD);
        for (int i = 0; i < 12; i++) begin
            if (i > 0) step(0, 0, 0, 0, 0);
            checks++;
            if ({vld, done, busy, m04} !== {e_vld, e_done, m_run, e_m04}) begin
                errors++;
                $display("FAIL basic cyc=%0d got vld=%b done=%b busy=%b m04=%h want %b %b %b %h",
                         cyc, vld, done, busy, m04, e_vld, e_done, m_run, e_m04);
            end
            if (vld) begin got.push_back(m04[31:0]); last_issue = cyc; end
            if (done) done_cyc = cyc;
        end
        checks++;
        if (got.size() != 4) begin
            errors++;
            $display("FAIL basic_count got %0d nonces want 4", got.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (got[i] !== 32'(5 + i)) begin
                    errors++;
                    $display("FAIL basic_seq[%0d] got %h want %h", i, got[i], 32'(5 + i));
                end
            end
        end
        checks++;
        if (done_cyc - last_issue != DEPTH) begin
            errors++;
            $display("FAIL basic_done_gap got %0d want %0d", done_cyc - last_issue, DEPTH);
        end
    endtask

    task automatic test_hold();
        logic [31:0] got[$];
        longint at[$];
        bit hpat[12] = '{0, 0, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0};
        step(1, 0, 32'd5, 32'd8, 32'h0BAD_F00D);
        for (int i = 0; i < 12; i++) begin
            step(0, hpat[i], 0, 0, 0);
            checks++;
            if ({vld, done, busy, m04} !== {e_vld, e_done, m_run, e_m04}) begin
                errors++;
                $display("FAIL hold cyc=%0d got vld=%b done=%b busy=%b m04=%h want %b %b %b %h",
                         cyc, vld, done, busy, m04, e_vld, e_done, m_run, e_m04);
            end
            if (vld) begin got.push_back(m04[31:0]); at.push_back(cyc); end
        end
        checks++;
        if (got.size() != 4) begin
            errors++;
            $display("FAIL hold_count got %0d nonces want 4", got.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (got[i] !== 32'(5 + i)) begin
                    errors++;
                    $display("FAIL hold_seq[%0d] got %h want %h", i, got[i], 32'(5 + i));
                end
            end
            checks++;
            if (at[2] - at[1] != 4) begin
                errors++;
                $display("FAIL hold_gap got %0d want 4", at[2] - at[1]);
            end
        end
    endtask

    task automatic test_wrap_single();
        logic [31:0] exp_w[4] = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0, 32'h1};
        int n_w, n_s, n_done;
        n_w = 0; n_s = 0; n_done = 0;
        step(1, 0, 32'hFFFF_FFFE, 32'd1, 32'h1357_9BDF);
        for (int i = 0; i < 10; i++) begin
            step(0, 0, 0, 0, 0);
            checks++;
            if ({vld, done, busy, m04} !== {e_vld, e_done, m_run, e_m04}) begin
                errors++;
                $display("FAIL wrap cyc=%0d got vld=%b done=%b busy=%b m04=%h want %b %b %b %h",
                         cyc, vld, done, busy, m04, e_vld, e_done, m_run, e_m04);
            end
            if (vld) begin
                checks++;
                if (n_w > 3 || m04[31:0] !== exp_w[n_w & 3]) begin
                    errors++;
                    $display("FAIL wrap_seq[%0d] got %h want %h", n_w, m04[31:0], exp_w[n_w & 3]);
                end
                n_w++;
            end
            if (done) n_done++;
        end
        step(1, 0, 32'd7, 32'd7, 32'h2468_ACE0);
        for (int i = 0; i < 8; i++) begin
            step(0, 0, 0, 0, 0);
            checks++;
            if ({vld, done, busy, m04} !== {e_vld, e_done, m_run, e_m04}) begin
                errors++;
                $display("FAIL single cyc=%0d got vld=%b done=%b busy=%b m04=%h want %b %b %b %h",
                         cyc, vld, done, busy, m04, e_vld, e_done, m_run, e_m04);
            end
            if (vld) n_s++;
            if (done) n_done++;
        end
        checks++;
        if (n_w != 4 || n_s != 1 || n_done != 2) begin
            errors++;
            $display("FAIL wrap_single_counts got wrap=%0d single=%0d done=%0d want 4 1 2",
                     n_w, n_s, n_done);
        end
    endtask

    task automatic test_abort();
        // Stimulus table: valid, start/end (start==end unless noted); edge index implied.
        bit          tv[26];
        logic [31:0] ts[26], te[26];
        int n_done, n_vld;
        n_done = 0; n_vld = 0;
        foreach (tv[i]) begin tv[i] = 0; ts[i] = 0; te[i] = 0; end
        tv[0] = 1; ts[0] = 10;  te[0] = 20;   // old range
        tv[2] = 1; ts[2] = 100; te[2] = 100;  // 2nd RUN cycle
        tv[5] = 1; ts[5] = 100; te[5] = 100;  // in DRAIN
        tv[12] = 1; ts[12] = 50; te[12] = 50; // issue at 13, done decision at 17
        tv[17] = 1; ts[17] = 60; te[17] = 60; // collides with done decision
        for (int i = 0; i < 26; i++) begin
            step(tv[i], 0, ts[i], te[i], 32'hC0DE_0000 | 32'(i));
            checks++;
            if ({vld, done, busy, m04} !== {e_vld, e_done, m_run, e_m04}) begin
                errors++;
                $display("FAIL abort cyc=%0d got vld=%b done=%b busy=%b m04=%h want %b %b %b %h",
                         cyc, vld, done, busy, m04, e_vld, e_done, m_run, e_m04);
            end
            if (vld) n_vld++;
            if (done) n_done++;
        end
        checks++;
        if (n_vld != 5 || n_done != 2) begin
            errors++;
            $display("FAIL abort_counts got vld=%0d done=%0d want 5 2", n_vld, n_done);
        end
    endtask

    task automatic test_random();
        logic [31:0] s;
        for (int i = 0; i < 600; i++) begin
            s = $urandom();
            if ($urandom_range(0, 99) < 5)
                step(1, 0, s, s + $urandom_range(0, 7), $urandom());
            else
                step(0, $urandom_range(0, 99) < 30, s, $urandom(), $urandom());
            checks++;
            if ({vld, done, busy, m04} !== {e_vld, e_done, m_run, e_m04}) begin
                errors++;
                $display("FAIL random cyc=%0d got vld=%b done=%b busy=%b m04=%h want %b %b %b %h",
                         cyc, vld, done, busy, m04, e_vld, e_done, m_run, e_m04);
            end
        end
    endtask

    task automatic test_w64();
        logic [67:0] want[4];
        valid = 0; hold = 0;
        // {vld, done, busy, m04} after each edge following the strobe.
        want[0] = {1'b0, 1'b0, 1'b1, 64'h0};
        want[1] = {1'b1, 1'b0, 1'b1, 64'h1234};
        want[2] = {1'b0, 1'b1, 1'b0, 64'h1234};
        want[3] = {1'b0, 1'b0, 1'b0, 64'h1234};
        for (int i = 0; i < 4; i++) begin
            valid_w = (i == 0); hold_w = 0;
            start_w = 64'h1234; end_w = 64'h1234; base_w = {$urandom(), $urandom()};
            @(posedge clk);
            #1;
            checks++;
            if ({1'b0, vld_w, done_w, busy_w, m04_w} !== want[i]) begin
                errors++;
                $display("FAIL w64 step=%0d got vld=%b done=%b busy=%b m04=%h want %h",
                         i, vld_w, done_w, busy_w, m04_w, want[i]);
            end
        end
    endtask

    initial begin
        cyc = 0;
        test_reset();
        test_basic();
        test_hold();
        test_wrap_single();
        test_abort();
        test_random();
        test_w64();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
